matrix_ram_loader: RTL and testbench

MATRIX_RAM_LOADER -- requirements
Module: matrix_ram_loader

---
 rtl/matrix_ram_loader.sv | 128 ++++++++++++
 tb/tb_matrix_ram_loader.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_ram_loader.sv
// matrix_ram_loader: a 16-byte writable matrix store that replaces a read-only
// table. A burst loader fills it from a valid/ready byte stream, and the
// determinant calculator reads it through a zero-latency combinational port.
// Optional feature macro: LOADER_CHECKSUM_EN adds a running modulo-256 sum of
// the accepted bytes. Without the macro, checksum is tied to zero.
module matrix_ram_loader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] load_base,
  input  logic [ADDR_W:0]   load_len,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              load_done,
  output logic              busy,
  input  logic [ADDR_W-1:0] addrBus,
  output logic [DATA_W-1:0] outBus,
  output logic [DATA_W-1:0] checksum
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wrPtr_q, wrPtr_d;
  logic [ADDR_W:0]     remaining_q, remaining_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic                transfer;

  // Controller state and burst bookkeeping registers. Reset wins over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      wrPtr_q     <= '0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      wrPtr_q     <= wrPtr_d;
      remaining_q <= remaining_d;
    end
  end

  // Next-state logic and handshake outputs. The pointer wraps naturally at ADDR_W bits.
  always_comb begin
    state_d     = state_q;
    wrPtr_d     = wrPtr_q;
    remaining_d = remaining_q;
    in_ready    = 1'b0;
    busy        = 1'b0;
    load_done   = 1'b0;
    transfer    = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_start) begin
          wrPtr_d     = load_base;
          remaining_d = load_len;
          state_d     = (load_len == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        transfer = in_valid;
        if (in_valid) begin
          wrPtr_d     = wrPtr_q + ADDR_W'(1);
          remaining_d = remaining_q - (ADDR_W + 1)'(1);
          if (remaining_q == (ADDR_W + 1)'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        busy      = 1'b1;
        load_done = 1'b1;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Byte storage. Reset clears every location, so a write in a reset cycle never lands.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (transfer) begin
      mem_q[wrPtr_q] <= in_data;
    end
  end

  // The read port is asynchronous, so a same-cycle write appears on the next cycle.
  assign outBus = mem_q[addrBus];

`ifdef LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_q;
  logic              startAccept;

  assign startAccept = (state_q == IDLE) && load_start;

  // Running sum of accepted bytes. It clears when a burst starts and holds after the burst.
  always_ff @(posedge clk) begin
    if (reset) begin
      checksum_q <= '0;
    end else if (startAccept) begin
      checksum_q <= '0;
    end else if (transfer) begin
      checksum_q <= checksum_q + in_data;
    end
  end

  assign checksum = checksum_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_matrix_ram_loader.sv
// Scoreboard bench for matrix_ram_loader. Stimulus tasks push the expected
// read bytes and the expected load_done events (cycle and checksum) into
// queues. A negedge monitor pops and compares these whenever the DUT presents them.
module tb_matrix_ram_loader;

  typedef struct {
    int         cyc;
    logic [7:0] sum;
  } doneRec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       load_start;
  logic [3:0] load_base;
  logic [4:0] load_len;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       load_done;
  logic       busy;
  logic [3:0] addrBus;
  logic [7:0] outBus;
  logic [7:0] checksum;

  int         testsRun = 0;
  int         failCnt  = 0;
  int         cycleCnt = 0;
  logic       rdStrobe = 1'b0;
  logic [7:0] readQ [$];
  doneRec_t   doneQ [$];
  logic [7:0] expMem [16];
  logic [7:0] dataVec [16];
  logic [7:0] rdExp;
  doneRec_t   doneRec;

  matrix_ram_loader #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_start (load_start),
    .load_base  (load_base),
    .load_len   (load_len),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .load_done  (load_done),
    .busy       (busy),
    .addrBus    (addrBus),
    .outBus     (outBus),
    .checksum   (checksum)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Cycle index used to time load_done against load_start.
  always @(posedge clk) cycleCnt++;

  // Monitor: compare read data and completion events against the queued expectations.
  always @(negedge clk) begin
    if (rdStrobe) begin
      testsRun++;
      if (readQ.size() == 0) begin
        failCnt++;
        $display("[TB] FAIL read: unexpected strobe at addr=%0d", addrBus);
      end else begin
        rdExp = readQ.pop_front();
        if (outBus !== rdExp) begin
          failCnt++;
          $display("[TB] FAIL read addr=%0d: got %02h expected %02h", addrBus, outBus, rdExp);
        end
      end
    end
    if (load_done === 1'b1) begin
      testsRun++;
      if (doneQ.size() == 0) begin
        failCnt++;
        $display("[TB] FAIL load_done: unexpected pulse at cycle %0d", cycleCnt);
      end else begin
        doneRec = doneQ.pop_front();
        if (cycleCnt != doneRec.cyc || checksum !== doneRec.sum) begin
          failCnt++;
          $display("[TB] FAIL load_done: cycle %0d checksum %02h expected cycle %0d checksum %02h",
                   cycleCnt, checksum, doneRec.cyc, doneRec.sum);
        end
      end
    end
  end

  task automatic checkBit(input string name, input logic actual, input logic expected);
    testsRun++;
    if (actual !== expected) begin
      failCnt++;
      $display("[TB] FAIL %s: got %b expected %b", name, actual, expected);
    end
  endtask

  task automatic checkOutput(input logic [3:0] addr, input logic [7:0] expected);
    addrBus = addr;
    readQ.push_back(expected);
    rdStrobe = 1'b1;
    @(posedge clk); #1;
    rdStrobe = 1'b0;
  endtask

  task automatic sweepMem();
    for (int a = 0; a < 16; a++) begin
      checkOutput(4'(a), expMem[a]);
    end
  endtask

  // Burst driver. Optional features: one idle cycle between bytes, a read-during-write
  // probe, and a load_start poke while the loader is busy.
  task automatic applyStimulus(input logic [3:0] base, input int len, input bit stall,
                               input bit probe, input bit poke, input int expLat);
    doneRec_t   r;
    logic [7:0] sum;
    logic [3:0] p;
    @(posedge clk); #1;
    load_start = 1'b1;
    load_base  = base;
    load_len   = 5'(len);
    sum = 8'h00;
    for (int i = 0; i < len; i++) sum = sum + dataVec[i];
`ifndef LOADER_CHECKSUM_EN
    sum = 8'h00;
`endif
    r.cyc = cycleCnt + expLat;
    r.sum = sum;
    doneQ.push_back(r);
    @(posedge clk); #1;
    load_start = 1'b0;
    p = base;
    for (int i = 0; i < len; i++) begin
      in_valid = 1'b1;
      in_data  = dataVec[i];
      if (poke && i == 0) begin
        load_start = 1'b1;
        load_base  = 4'd9;
        load_len   = 5'd1;
      end
      if (probe && i < 2) begin
        addrBus = base;
        readQ.push_back((i == 0) ? expMem[base] : dataVec[0]);
        rdStrobe = 1'b1;
      end
      @(posedge clk); #1;
      load_start = 1'b0;
      rdStrobe   = 1'b0;
      expMem[p]  = dataVec[i];
      p = p + 4'd1;
      if (stall && i < len - 1) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0;
  endtask

  // Directed test sequence.
  initial begin
    reset = 1'b1; load_start = 1'b0; load_base = '0; load_len = '0;
    in_valid = 1'b0; in_data = '0; addrBus = '0;
    for (int i = 0; i < 16; i++) expMem[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // State after reset: the memory reads back zero and the loader is idle.
    checkBit("resetInReady", in_ready, 1'b0);
    checkBit("resetBusy", busy, 1'b0);
    checkBit("resetDone", load_done, 1'b0);
    sweepMem();

    // Back-to-back burst of four bytes at base 0, with a read-during-write probe.
    dataVec[0] = 8'h01; dataVec[1] = 8'h02; dataVec[2] = 8'h03; dataVec[3] = 8'h04;
    applyStimulus(4'd0, 4, 1'b0, 1'b1, 1'b0, 5);
    checkOutput(4'd3, 8'h04);
    sweepMem();

    // Burst that wraps from address 15 to address 0.
    dataVec[0] = 8'hAA; dataVec[1] = 8'hBB; dataVec[2] = 8'hCC; dataVec[3] = 8'hDD;
    applyStimulus(4'd14, 4, 1'b0, 1'b0, 1'b0, 5);
    checkOutput(4'd14, 8'hAA);
    checkOutput(4'd15, 8'hBB);
    checkOutput(4'd0, 8'hCC);
    checkOutput(4'd1, 8'hDD);
    checkOutput(4'd2, 8'h03);

    // Stalled burst, followed by stray in_valid cycles after completion.
    dataVec[0] = 8'h5A; dataVec[1] = 8'h5B; dataVec[2] = 8'h5C;
    applyStimulus(4'd6, 3, 1'b1, 1'b0, 1'b0, 6);
    in_valid = 1'b1; in_data = 8'hEE;
    repeat (3) begin @(posedge clk); #1; end
    in_valid = 1'b0;
    sweepMem();

    // load_start pulses during LOAD and during DONE are ignored.
    dataVec[0] = 8'h55; dataVec[1] = 8'h66;
    applyStimulus(4'd4, 2, 1'b0, 1'b0, 1'b1, 3);
    load_start = 1'b1; load_base = 4'd0; load_len = 5'd0;
    @(posedge clk); #1;
    load_start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    sweepMem();

    // A zero-length burst completes on the next cycle with busy high for one cycle.
    applyStimulus(4'd3, 0, 1'b0, 1'b0, 1'b0, 1);
    checkBit("zeroLenBusyDone", busy, 1'b1);
    @(posedge clk); #1;
    checkBit("zeroLenBusyAfter", busy, 1'b0);
    sweepMem();

    // Reset in the middle of a burst: there is no done pulse and the memory is cleared.
    @(posedge clk); #1;
    load_start = 1'b1; load_base = 4'd0; load_len = 5'd4;
    @(posedge clk); #1;
    load_start = 1'b0; in_valid = 1'b1; in_data = 8'h11;
    @(posedge clk); #1;
    in_data = 8'h22;
    @(posedge clk); #1;
    in_data = 8'h33; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 16; i++) expMem[i] = 8'h00;
    checkBit("abortInReady", in_ready, 1'b0);
    checkBit("abortBusy", busy, 1'b0);
    checkBit("abortDone", load_done, 1'b0);
    repeat (4) begin @(posedge clk); #1; end
    sweepMem();

    // Drain the scoreboard within a bounded number of cycles.
    for (int w = 0; w < 20 && (doneQ.size() != 0 || readQ.size() != 0); w++) begin
      @(posedge clk); #1;
    end
    while (doneQ.size() != 0) begin
      doneRec = doneQ.pop_front();
      testsRun++; failCnt++;
      $display("[TB] FAIL load_done: missing pulse, got none expected cycle %0d", doneRec.cyc);
    end
    while (readQ.size() != 0) begin
      rdExp = readQ.pop_front();
      testsRun++; failCnt++;
      $display("[TB] FAIL read: pending, got none expected %02h", rdExp);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failCnt);
    $finish;
  end

endmodule
